// File: rtl/spi_led_pkg.sv
// rtl/spi_led_pkg.sv - command codes and parser state for the SPI LED PWM controller
package spi_led_pkg;

  localparam logic [7:0] CMD_NEXT   = 8'h08;
  localparam logic [7:0] CMD_TOGGLE = 8'h24;
  localparam logic [7:0] CMD_MASK   = 8'h30;
  localparam logic [3:0] CMD_WDUTY  = 4'h4;
  localparam logic [3:0] CMD_RDUTY  = 4'h8;

  typedef enum logic [1:0] {
    P_IDLE,
    P_W_DUTY,
    P_W_MASK
  } parse_state_t;

endpackage

// File: rtl/spi_slave_byte.sv
// rtl/spi_slave_byte.sv - oversampled SPI mode-0 slave, byte-wide rx/tx
module spi_slave_byte (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       cs_rise,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  logic [2:0] cs_sr;
  logic [2:0] sck_sr;
  logic [1:0] mosi_sr;
  logic [2:0] bit_cnt;
  logic [7:0] tx_buf;
  logic       cs_act;
  logic       cs_fall;
  logic       sck_rise;
  logic       sck_fall;

  assign cs_act   = ~cs_sr[1];
  assign cs_fall  = cs_sr[2] & ~cs_sr[1];
  assign cs_rise  = ~cs_sr[2] & cs_sr[1];
  assign sck_rise = cs_act & sck_sr[1] & ~sck_sr[2];
  assign sck_fall = cs_act & ~sck_sr[1] & sck_sr[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sr       <= 3'b111;
      sck_sr      <= 3'b000;
      mosi_sr     <= 2'b00;
      bit_cnt     <= 3'd0;
      rx_data     <= 8'h00;
      tx_buf      <= 8'h00;
      byte_valid  <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      cs_sr       <= {cs_sr[1:0], spi_cs_n};
      sck_sr      <= {sck_sr[1:0], spi_clk};
      mosi_sr     <= {mosi_sr[0], spi_mosi};
      byte_valid  <= 1'b0;
      spi_miso_oe <= cs_act;
      // First bit goes out at CS fall; later bits leave on each SCK fall.
      if (cs_fall) begin
        bit_cnt  <= 3'd0;
        spi_miso <= tx_data[7];
        tx_buf   <= {tx_data[6:0], 1'b0};
      end else if (cs_rise) begin
        bit_cnt <= 3'd0;
      end else begin
        if (sck_rise) begin
          rx_data    <= {rx_data[6:0], mosi_sr[1]};
          bit_cnt    <= bit_cnt + 3'd1;
          byte_valid <= (bit_cnt == 3'd7);
        end
        if (byte_valid) begin
          tx_buf <= tx_data;
        end else if (sck_fall) begin
          spi_miso <= tx_buf[7];
          tx_buf   <= {tx_buf[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_led_pwm_ctrl.sv
// rtl/spi_led_pwm_ctrl.sv - SPI-controlled N-channel LED PWM driver
module spi_led_pwm_ctrl
  import spi_led_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int PWM_BITS    = 8,
  parameter int PRESC_BITS  = 5,
  parameter int DUTY_RESET  = 32,
  parameter int LED_ACT_LOW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_cs_n,
  input  logic            spi_clk,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic            spi_miso_oe,
  output logic [N_CH-1:0] led_out,
  output logic            glob_en
);

  localparam logic [7:0]          DUTY_RESET_B = 8'(DUTY_RESET);
  localparam logic [PWM_BITS-1:0] DUTY_INIT    = DUTY_RESET_B[7 -: PWM_BITS];
  localparam logic [N_CH-1:0]     LED_OFF      = (LED_ACT_LOW != 0) ? {N_CH{1'b1}} : '0;

  logic [7:0]          rx_byte;
  logic                byte_valid;
  logic                cs_rise;
  logic [7:0]          tx_data;
  logic [7:0]          tx_pend;
  logic [7:0]          rd_byte;
  logic                rd_cmd;
  parse_state_t        state;
  logic [3:0]          wch;
  logic [N_CH-1:0]     mask;
  logic [N_CH-1:0]     mask_rot;
  logic [PWM_BITS-1:0] duty     [N_CH];
  logic [PWM_BITS-1:0] duty_act [N_CH];
  logic [PRESC_BITS-1:0] presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_CH-1:0]     led_on;

  spi_slave_byte u_spi (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_cs_n    (spi_cs_n),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .tx_data     (tx_data),
    .rx_data     (rx_byte),
    .byte_valid  (byte_valid),
    .cs_rise     (cs_rise),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
  );

  assign mask_rot = N_CH'({mask, mask} >> (N_CH - 1));
  assign rd_cmd   = (state == P_IDLE) && (rx_byte[7:4] == CMD_RDUTY);

  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < N_CH; i++) begin
      if (rx_byte[3:0] == 4'(i)) rd_byte[7 -: PWM_BITS] = duty[i];
    end
  end

  // Readback replaces the echo on the byte that follows a read command.
  assign tx_data = byte_valid ? (rd_cmd ? rd_byte : rx_byte) : tx_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= P_IDLE;
      wch     <= 4'd0;
      mask    <= N_CH'(1);
      glob_en <= 1'b0;
      tx_pend <= 8'h00;
      for (int i = 0; i < N_CH; i++) duty[i] <= DUTY_INIT;
    end else begin
      if (byte_valid) begin
        tx_pend <= tx_data;
        case (state)
          P_IDLE: begin
            if (rx_byte == CMD_NEXT) begin
              mask    <= (mask == '0) ? N_CH'(1) : mask_rot;
              glob_en <= 1'b1;
            end else if (rx_byte == CMD_TOGGLE) begin
              glob_en <= ~glob_en;
            end else if (rx_byte == CMD_MASK) begin
              state <= P_W_MASK;
            end else if (rx_byte[7:4] == CMD_WDUTY) begin
              state <= P_W_DUTY;
              wch   <= rx_byte[3:0];
            end
          end
          P_W_DUTY: begin
            for (int i = 0; i < N_CH; i++) begin
              if (wch == 4'(i)) duty[i] <= rx_byte[7 -: PWM_BITS];
            end
            state <= P_IDLE;
          end
          P_W_MASK: begin
            mask  <= rx_byte[N_CH-1:0];
            state <= P_IDLE;
          end
          default: state <= P_IDLE;
        endcase
      end
      // A byte completing together with CS rise is still applied above.
      if (cs_rise) state <= P_IDLE;
    end
  end

  always_comb begin
    led_on = '0;
    for (int i = 0; i < N_CH; i++) begin
      led_on[i] = glob_en & mask[i] & (pwm_cnt < duty_act[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc   <= '0;
      pwm_cnt <= '0;
      led_out <= LED_OFF;
      for (int i = 0; i < N_CH; i++) duty_act[i] <= DUTY_INIT;
    end else begin
      presc   <= presc + 1'b1;
      led_out <= led_on ^ LED_OFF;
      if (presc == '1) begin
        pwm_cnt <= pwm_cnt + 1'b1;
        // Duty only changes at the period boundary so no pulse is ever truncated.
        if (pwm_cnt == '1) begin
          for (int i = 0; i < N_CH; i++) duty_act[i] <= duty[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_led_pwm_ctrl.sv
// tb/tb_spi_led_pwm_ctrl.sv - directed scoreboard bench for spi_led_pwm_ctrl
module tb_spi_led_pwm_ctrl;

  localparam int N_CH = 3;
  localparam int H    = 6;
  localparam int TICK = 8;
  localparam int P    = 256 * TICK;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            spi_cs_n = 1'b1;
  logic            spi_clk = 1'b0;
  logic            spi_mosi = 1'b0;
  logic            spi_miso;
  logic            spi_miso_oe;
  logic [N_CH-1:0] led_out;
  logic            glob_en;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  logic [7:0]      m_duty [N_CH];
  logic [N_CH-1:0] m_mask;
  logic            m_glob;
  int              m_state;
  logic [3:0]      m_ch;
  logic [7:0]      m_pend;

  always #5 clk = ~clk;

  spi_led_pwm_ctrl #(
    .N_CH        (N_CH),
    .PWM_BITS    (8),
    .PRESC_BITS  (3),
    .DUTY_RESET  (32),
    .LED_ACT_LOW (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_cs_n    (spi_cs_n),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .led_out     (led_out),
    .glob_en     (glob_en)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) m_duty[i] = 8'd32;
    m_mask  = 3'b001;
    m_glob  = 1'b0;
    m_state = 0;
    m_ch    = 4'd0;
    m_pend  = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] nxt;
    exp_q.push_back(m_pend);
    nxt = b;
    case (m_state)
      0: begin
        if (b == 8'h08) begin
          m_mask = (m_mask == 3'b000) ? 3'b001 : {m_mask[1:0], m_mask[2]};
          m_glob = 1'b1;
        end else if (b == 8'h24) begin
          m_glob = ~m_glob;
        end else if (b == 8'h30) begin
          m_state = 2;
        end else if (b[7:4] == 4'h4) begin
          m_state = 1;
          m_ch    = b[3:0];
        end else if (b[7:4] == 4'h8) begin
          nxt = 8'h00;
          for (int i = 0; i < N_CH; i++) if (int'(b[3:0]) == i) nxt = m_duty[i];
        end
      end
      1: begin
        for (int i = 0; i < N_CH; i++) if (int'(m_ch) == i) m_duty[i] = b;
        m_state = 0;
      end
      default: begin
        m_mask  = b[2:0];
        m_state = 0;
      end
    endcase
    m_pend = nxt;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      wclk(H);
      r[7-i] = spi_miso;
      spi_clk = 1'b1;
      wclk(H);
      spi_clk = 1'b0;
    end
  endtask

  // Sends every queued byte in one CS frame, optionally followed by a partial byte.
  task automatic run_cs(input string tag, input int tail_bits);
    logic [7:0] b;
    logic [7:0] r;
    int k;
    spi_cs_n = 1'b0;
    wclk(H);
    while (tx_q.size() > 0) begin
      b = tx_q.pop_front();
      model_byte(b);
      spi_bits(b, 8, r);
      rx_q.push_back(r);
    end
    if (tail_bits > 0) spi_bits(8'hA5, tail_bits, r);
    wclk(H);
    spi_cs_n = 1'b1;
    m_state = 0;
    wclk(2 * H);
    k = 0;
    while (exp_q.size() > 0) begin
      check($sformatf("%s_miso%0d", tag, k), 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
      k++;
    end
  endtask

  task automatic send1(input string tag, input logic [7:0] b);
    tx_q.push_back(b);
    run_cs(tag, 0);
    @(negedge clk);
    check({tag, "_glob"}, 32'(glob_en), 32'(m_glob));
  endtask

  task automatic wait_on(input int ch, output bit ok);
    bit prev;
    bit cur;
    ok = 1'b0;
    @(negedge clk);
    prev = (led_out[ch] == 1'b0);
    for (int k = 0; k < 3 * P; k++) begin
      @(negedge clk);
      cur = (led_out[ch] == 1'b0);
      if (cur && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = cur;
    end
  endtask

  task automatic count_pulse(input int ch, output int n);
    n = 1;
    for (int k = 0; k < P + 8; k++) begin
      @(negedge clk);
      if (led_out[ch] == 1'b0) n++;
      else break;
    end
  endtask

  task automatic pulse_check(input string tag, input int ch, input int exp);
    bit ok;
    int n;
    wait_on(ch, ok);
    check({tag, "_edge"}, 32'(ok), 32'd1);
    if (ok) begin
      count_pulse(ch, n);
      check({tag, "_len"}, 32'(n), 32'(exp));
    end
  endtask

  task automatic window_check(input string tag);
    int cnt [N_CH];
    int exp;
    for (int i = 0; i < N_CH; i++) cnt[i] = 0;
    repeat (P) begin
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) if (led_out[i] == 1'b0) cnt[i]++;
    end
    for (int i = 0; i < N_CH; i++) begin
      exp = (m_glob && m_mask[i]) ? int'(m_duty[i]) * TICK : 0;
      check($sformatf("%s_ch%0d", tag, i), 32'(cnt[i]), 32'(exp));
    end
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    check({tag, "_led"}, 32'(led_out), 32'(3'b111));
    check({tag, "_miso"}, 32'(spi_miso), 32'd0);
    check({tag, "_oe"}, 32'(spi_miso_oe), 32'd0);
    check({tag, "_glob"}, 32'(glob_en), 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    logic [7:0] r;

    model_reset();
    wclk(4);
    reset_check("rst");
    rst_n = 1'b1;
    wclk(4);

    send1("t1", 8'h08);
    pulse_check("t1_pulse", 1, 32 * TICK);
    window_check("t1_win");

    wait_on(1, ok);
    check("t2_edge", 32'(ok), 32'd1);
    fork
      count_pulse(1, n);
      begin
        tx_q.push_back(8'h41);
        tx_q.push_back(8'hC0);
        run_cs("t2", 0);
      end
    join
    check("t2_old_len", 32'(n), 32'(32 * TICK));
    pulse_check("t2_new", 1, 192 * TICK);

    tx_q.push_back(8'h81);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h87);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h80);
    tx_q.push_back(8'h00);
    run_cs("t3", 0);

    for (int k = 0; k < 3; k++) begin
      send1($sformatf("t4_next%0d", k), 8'h08);
      window_check($sformatf("t4_win%0d", k));
    end
    send1("t4_tog", 8'h24);
    window_check("t4_off");

    tx_q.push_back(8'h30);
    run_cs("t5_mask", 4);
    send1("t5_tog", 8'h24);
    window_check("t5_win");

    spi_cs_n = 1'b0;
    wclk(H);
    spi_bits(8'h30, 4, r);
    rst_n = 1'b0;
    wclk(2);
    reset_check("t6_rst");
    spi_cs_n = 1'b1;
    spi_clk  = 1'b0;
    wclk(4);
    rst_n = 1'b1;
    model_reset();
    wclk(4);
    send1("t6_cmd", 8'h08);
    window_check("t6_win");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
